// File: rtl/saradc_11b_pkg.sv
// Shared constants and scan-sequencer state encoding for the 11-bit SAR ADC digital core.
package saradc_11b_pkg;

  localparam int ADC_CHANNELS   = 16;
  localparam int ADC_CONV_BITS  = 11;
  localparam int ADC_OVERS_BITS = 2;
  localparam int ADC_FIFO_DEPTH = 4;
  localparam int SCAN_SUM_W     = ADC_CONV_BITS + 3;

  typedef enum logic [2:0] {
    SCAN_IDLE   = 3'd0,
    SCAN_SELECT = 3'd1,
    SCAN_REQ    = 3'd2,
    SCAN_WAIT   = 3'd3,
    SCAN_PUSH   = 3'd4
  } scan_state_t;

endpackage

// File: rtl/saradc_11b_dig_scan_ctrl_if.sv
// Conversion request/ack/done protocol plus the result valid/ready stream of the scan controller.
interface saradc_11b_dig_scan_ctrl_if import saradc_11b_pkg::*; #(
  parameter int N_CHANNELS  = ADC_CHANNELS,
  parameter int N_CONV_BITS = ADC_CONV_BITS
) ();

  localparam int CH_W = $clog2(N_CHANNELS);

  logic                   conv_req_o;
  logic [CH_W-1:0]        conv_ch_o;
  logic                   conv_ack_i;
  logic                   conv_done_i;
  logic [N_CONV_BITS-1:0] conv_data_i;
  logic                   res_valid_o;
  logic [CH_W-1:0]        res_ch_o;
  logic [N_CONV_BITS+2:0] res_data_o;
  logic                   res_ready_i;

  modport master (
    output conv_req_o, conv_ch_o, res_valid_o, res_ch_o, res_data_o,
    input  conv_ack_i, conv_done_i, conv_data_i, res_ready_i
  );

  modport slave (
    input  conv_req_o, conv_ch_o, res_valid_o, res_ch_o, res_data_o,
    output conv_ack_i, conv_done_i, conv_data_i, res_ready_i
  );

endinterface

// File: rtl/saradc_11b_dig_result_fifo.sv
// Synchronous show-ahead FIFO: o_rdata always presents the head entry while not empty.
module saradc_11b_dig_result_fifo import saradc_11b_pkg::*; #(
  parameter int DEPTH = ADC_FIFO_DEPTH,
  parameter int WIDTH = SCAN_SUM_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_rd && !o_empty;
  // a write into a full FIFO is still taken when the head leaves in the same cycle
  assign w_push  = i_wr && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/saradc_11b_dig_scan_ctrl.sv
// Scan sequencer: walks the channel mask, oversamples each channel and queues {channel, sum} results.
module saradc_11b_dig_scan_ctrl import saradc_11b_pkg::*; #(
  parameter int N_CHANNELS   = ADC_CHANNELS,
  parameter int N_CONV_BITS  = ADC_CONV_BITS,
  parameter int N_OVERS_BITS = ADC_OVERS_BITS,
  parameter int FIFO_DEPTH   = ADC_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    cfg_enable_i,
  input  logic [N_CHANNELS-1:0]   cfg_ch_mask_i,
  input  logic                    cfg_continuous_i,
  input  logic [N_OVERS_BITS-1:0] cfg_overs_i,
  input  logic                    trig_i,
  saradc_11b_dig_scan_ctrl_if.master bus,
  output logic                    busy_o,
  output logic                    scan_done_o,
  output logic                    overflow_o
);

  localparam int CH_W  = $clog2(N_CHANNELS);
  localparam int PTR_W = CH_W + 1;
  localparam int SUM_W = N_CONV_BITS + 3;
  localparam int CNT_W = 4;

  localparam logic [2:0] S_IDLE   = SCAN_IDLE;
  localparam logic [2:0] S_SELECT = SCAN_SELECT;
  localparam logic [2:0] S_REQ    = SCAN_REQ;
  localparam logic [2:0] S_WAIT   = SCAN_WAIT;
  localparam logic [2:0] S_PUSH   = SCAN_PUSH;

  logic [2:0]       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [CH_W-1:0]  r_ch;
  logic [1:0]       r_overs;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum;
  logic             r_abort;
  logic             r_scan_done;
  logic             r_overflow;

  logic [N_CHANNELS-1:0] w_avail;
  logic                  w_found;
  logic [CH_W-1:0]       w_sel;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_valid;
  logic [CH_W+SUM_W-1:0] w_head;

  function automatic logic [1:0] clamp_overs(input logic [N_OVERS_BITS-1:0] v);
    return (32'(v) > 32'd3) ? 2'd3 : 2'(v);
  endfunction

  // channels below the pointer were already converted in this scan
  assign w_avail = cfg_ch_mask_i & ~((N_CHANNELS'(1) << r_ptr) - N_CHANNELS'(1));

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = N_CHANNELS-1; i >= 0; i--) begin
      if (w_avail[i]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end

  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_last     = (w_cnt_next == (CNT_W'(1) << r_overs));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_overs     <= '0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ptr   <= '0;
          r_abort <= 1'b0;
          if (cfg_enable_i && (|cfg_ch_mask_i) && (trig_i || cfg_continuous_i))
            r_state <= S_SELECT;
        end
        S_SELECT: begin
          r_cnt   <= '0;
          r_overs <= clamp_overs(cfg_overs_i);
          if (!cfg_enable_i) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_ch    <= w_sel;
            r_state <= S_REQ;
          end else begin
            r_scan_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_REQ: begin
          // an accepted request must be seen through to done even when disabled
          if (bus.conv_ack_i) begin
            r_abort <= !cfg_enable_i;
            r_state <= S_WAIT;
          end else if (!cfg_enable_i) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!cfg_enable_i) r_abort <= 1'b1;
          if (bus.conv_done_i) begin
            r_cnt <= w_cnt_next;
            if (r_abort || !cfg_enable_i) r_state <= S_IDLE;
            else if (w_last)              r_state <= S_PUSH;
            else                          r_state <= S_REQ;
          end
        end
        S_PUSH: begin
          r_ptr   <= {1'b0, r_ch} + PTR_W'(1);
          r_state <= S_SELECT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_SELECT)
      r_sum <= '0;
    else if (r_state == S_WAIT && bus.conv_done_i)
      r_sum <= r_sum + SUM_W'(bus.conv_data_i);
  end

  assign w_push = (r_state == S_PUSH);
  assign w_pop  = w_valid && bus.res_ready_i;

  always_ff @(posedge clk or posedge res) begin
    if (res)                               r_overflow <= 1'b0;
    else if (!cfg_enable_i)                r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
  end

  saradc_11b_dig_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CH_W + SUM_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (res),
    .i_wr    (w_push),
    .i_wdata ({r_ch, r_sum}),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_valid         = !w_empty;
  assign bus.res_valid_o = w_valid;
  assign bus.res_ch_o    = w_valid ? w_head[CH_W+SUM_W-1:SUM_W] : '0;
  assign bus.res_data_o  = w_valid ? w_head[SUM_W-1:0] : '0;
  assign bus.conv_req_o  = (r_state == S_REQ);
  assign bus.conv_ch_o   = r_ch;
  assign busy_o          = (r_state != S_IDLE);
  assign scan_done_o     = r_scan_done;
  assign overflow_o      = r_overflow;

endmodule
